// File: rtl/enemy_spawner_pkg.sv
// Shared game package: FSM state encodings, playfield geometry and the
// LFSR step function used by the spawner and the other game stages.
package enemy_spawner_pkg;

  typedef logic [2:0] state_t;

  // Spawner FSM states
  // state    | meaning
  // IDLE     | no game running, enemy parked off screen
  // WAIT_GAP | counting ticks until the next enemy may appear
  // SPAWN    | one clk: pick a lane and place the enemy at the top
  // ACTIVE   | enemy on screen, waiting for it to leave the bottom
  // FROZEN   | collision seen, everything holds until restart
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WAIT_GAP = 3'd1;
  localparam logic [2:0] ST_SPAWN    = 3'd2;
  localparam logic [2:0] ST_ACTIVE   = 3'd3;
  localparam logic [2:0] ST_FROZEN   = 3'd4;

  localparam int GAME_PARK_Y   = 620;
  localparam int GAME_BOTTOM_Y = 600;
  localparam int GAME_LANE_W   = 80;

  localparam int POS_W = 10;
  localparam int GAP_W = 8;

  // One step of the 16-bit Galois LFSR with tap mask 16'hB400
  function automatic logic [15:0] lfsr16_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

endpackage

// File: rtl/enemy_spawner_if.sv
// Game-logic side bus of the enemy spawner: update strobes and feedback in,
// spawn coordinates and status out.
interface enemy_spawner_if;
  import enemy_spawner_pkg::*;

  logic             tick;
  logic             start;
  logic             collision;
  logic [POS_W-1:0] enemy_pos_y;
  logic [POS_W-1:0] offset_x;
  logic [POS_W-1:0] offset_y;
  logic             enable;
  logic [7:0]       spawn_count;
  logic             frozen;

  modport master (
    output tick, start, collision, enemy_pos_y,
    input  offset_x, offset_y, enable, spawn_count, frozen
  );

  modport slave (
    input  tick, start, collision, enemy_pos_y,
    output offset_x, offset_y, enable, spawn_count, frozen
  );

endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; the seed must be nonzero so the register
// never locks up at zero.
module lfsr16
  import enemy_spawner_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] value
);

  logic [15:0] value_q, value_d;

  // Next LFSR value, advanced every clock
  always_comb value_d = lfsr16_next(value_q);

  // LFSR register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) value_q <= SEED;
    else        value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/enemy_spawner.sv
// Enemy spawner: waits a shrinking tick gap, picks a random lane that differs
// from the previous one, strobes the enemy stage and waits for the enemy to
// leave the screen. A collision freezes the game until the next start.
module enemy_spawner
  import enemy_spawner_pkg::*;
#(
  parameter int          NUM_LANES = 4,
  parameter int          LANE_X0   = 200,
  parameter int          LANE_W    = GAME_LANE_W,
  parameter int          PARK_Y    = GAME_PARK_Y,
  parameter int          BOTTOM_Y  = GAME_BOTTOM_Y,
  parameter int          GAP_TICKS = 30,
  parameter int          GAP_MIN   = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             reset,
  enemy_spawner_if.slave   bus
);

  localparam int LANE_BITS = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic [15:0]          lfsr_value;
  logic                 unused_lfsr;

  state_t               state_q, state_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [LANE_BITS-1:0] last_lane_q, last_lane_d;
  logic [POS_W-1:0]     offset_x_q, offset_x_d;
  logic [POS_W-1:0]     offset_y_q, offset_y_d;
  logic                 enable_q, enable_d;
  logic [7:0]           count_q, count_d;
  logic                 frozen_q, frozen_d;

  logic [LANE_BITS-1:0] lane_raw, lane_pick;
  logic signed [GAP_W+1:0] gap_diff;
  logic [GAP_W-1:0]     gap_reload;
  logic                 game_live;
  logic                 at_bottom;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .value (lfsr_value)
  );

  // Only the low lane bits pick a lane; the rest of the LFSR is for reuse elsewhere
  assign unused_lfsr = ^lfsr_value[15:LANE_BITS];
  assign lane_raw    = lfsr_value[LANE_BITS-1:0];

  // Never repeat the previous lane: bump to the next one, wrapping
  always_comb begin
    lane_pick = lane_raw;
    if (lane_raw == last_lane_q) lane_pick = LANE_BITS'(last_lane_q + LANE_BITS'(1));
  end

  // Signed subtraction so a large spawn_count can never wrap the gap
  assign gap_diff   = $signed((GAP_W+2)'(GAP_TICKS)) - $signed((GAP_W+2)'(count_q[7:2]));
  assign gap_reload = (gap_diff < $signed((GAP_W+2)'(GAP_MIN))) ? GAP_W'(GAP_MIN)
                                                                : gap_diff[GAP_W-1:0];

  assign game_live = (state_q == ST_WAIT_GAP) || (state_q == ST_SPAWN) || (state_q == ST_ACTIVE);
  assign at_bottom = (bus.enemy_pos_y >= POS_W'(BOTTOM_Y));

  // FSM next-state and datapath; collision overrides every other transition
  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    last_lane_d = last_lane_q;
    offset_x_d  = offset_x_q;
    offset_y_d  = offset_y_q;
    enable_d    = enable_q;
    count_d     = count_q;
    frozen_d    = frozen_q;

    if (game_live && bus.collision) begin
      state_d  = ST_FROZEN;
      enable_d = 1'b0;
      frozen_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_FROZEN: begin
          if (bus.start) begin
            state_d    = ST_WAIT_GAP;
            count_d    = 8'd0;
            gap_d      = GAP_W'(GAP_TICKS);
            offset_y_d = POS_W'(PARK_Y);
            enable_d   = 1'b0;
            frozen_d   = 1'b0;
          end
        end
        ST_WAIT_GAP: begin
          if (bus.tick) begin
            if (gap_q <= GAP_W'(1)) begin
              gap_d   = '0;
              state_d = ST_SPAWN;
            end else begin
              gap_d = gap_q - GAP_W'(1);
            end
          end
        end
        ST_SPAWN: begin
          offset_x_d  = POS_W'(LANE_X0) + POS_W'(LANE_W) * POS_W'(lane_pick);
          offset_y_d  = '0;
          last_lane_d = lane_pick;
          count_d     = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
          enable_d    = 1'b1;
          state_d     = ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (bus.tick) begin
            if (enable_q) begin
              enable_d = 1'b0;
            end else if (at_bottom) begin
              offset_y_d = POS_W'(PARK_Y);
              gap_d      = gap_reload;
              state_d    = ST_WAIT_GAP;
            end
          end
        end
        default: begin
          state_d  = ST_IDLE;
          enable_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      gap_q       <= '0;
      last_lane_q <= LANE_BITS'(NUM_LANES - 1);
      offset_x_q  <= POS_W'(LANE_X0);
      offset_y_q  <= POS_W'(PARK_Y);
      enable_q    <= 1'b0;
      count_q     <= 8'd0;
      frozen_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      last_lane_q <= last_lane_d;
      offset_x_q  <= offset_x_d;
      offset_y_q  <= offset_y_d;
      enable_q    <= enable_d;
      count_q     <= count_d;
      frozen_q    <= frozen_d;
    end
  end

  assign bus.offset_x    = offset_x_q;
  assign bus.offset_y    = offset_y_q;
  assign bus.enable      = enable_q;
  assign bus.spawn_count = count_q;
  assign bus.frozen      = frozen_q;

endmodule

// File: tb/tb_enemy_spawner.sv
// Directed bench for enemy_spawner: game start, spawn timing, lane choice,
// gap shrink and floor, saturation, collision freeze, restart and reset.
module tb_enemy_spawner;
  import enemy_spawner_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  enemy_spawner_if bus ();

  enemy_spawner dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference LFSR: shift right, fold taps 16,14,13,11 back in when bit 0 is set
  logic [15:0] m_lfsr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else if (m_lfsr[0]) m_lfsr <= {1'b1, m_lfsr[15:1]} ^ 16'h3400;
    else m_lfsr <= {1'b0, m_lfsr[15:1]};
  end

  int lfsr_cycles = 0;
  int lfsr_zero   = 0;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      lfsr_cycles++;
      if (dut.lfsr_value == 16'h0) lfsr_zero++;
    end
  end

  int m_last;
  int m_count;
  int prev_x;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick_once(input logic [9:0] pos, input logic col);
    @(negedge clk);
    bus.tick = 1'b1; bus.enemy_pos_y = pos; bus.collision = col;
    @(negedge clk);
    bus.tick = 1'b0; bus.collision = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  function automatic int exp_gap(input int cnt);
    int g;
    g = 30 - (cnt / 4);
    if (g < 8) g = 8;
    return g;
  endfunction

  // From WAIT_GAP with a known gap: tick down, check SPAWN and the placed enemy
  task automatic run_gap_and_spawn(input int gap);
    int lane_e;
    repeat (gap - 1) tick_once(10'd0, 1'b0);
    chk("pre_spawn_state", dut.state_q, ST_WAIT_GAP);
    chk("pre_spawn_gap", dut.gap_q, 1);
    tick_once(10'd0, 1'b0);
    chk("spawn_state", dut.state_q, ST_SPAWN);
    chk("spawn_enable_low", bus.enable, 0);
    lane_e = int'(m_lfsr[1:0]);
    if (lane_e == m_last) lane_e = (m_last + 1) % 4;
    @(negedge clk);
    if (m_count < 255) m_count++;
    chk("active_state", dut.state_q, ST_ACTIVE);
    chk("spawn_x", bus.offset_x, 200 + 80 * lane_e);
    chk("lane_changed", (int'(bus.offset_x) != prev_x), 1);
    chk("spawn_y", bus.offset_y, 0);
    chk("enable_high", bus.enable, 1);
    chk("spawn_count", bus.spawn_count, m_count);
    m_last = lane_e;
    prev_x = 200 + 80 * lane_e;
  endtask

  // From ACTIVE with enable high: consume the enable tick, then leave the screen
  task automatic finish_active();
    tick_once(10'd600, 1'b0);
    chk("enable_fall", bus.enable, 0);
    chk("bottom_ignored_while_en", dut.state_q, ST_ACTIVE);
    tick_once(10'd600, 1'b0);
    chk("bottom_state", dut.state_q, ST_WAIT_GAP);
    chk("bottom_park_y", bus.offset_y, 620);
    chk("reload_gap", dut.gap_q, exp_gap(m_count));
  endtask

  initial begin
    bus.tick = 1'b0; bus.start = 1'b0; bus.collision = 1'b0; bus.enemy_pos_y = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #10;
    chk("rst_state", dut.state_q, ST_IDLE);
    chk("rst_offset_x", bus.offset_x, 200);
    chk("rst_offset_y", bus.offset_y, 620);
    chk("rst_enable", bus.enable, 0);
    chk("rst_count", bus.spawn_count, 0);
    chk("rst_frozen", bus.frozen, 0);
    chk("rst_gap", dut.gap_q, 0);
    chk("rst_lfsr", dut.lfsr_value, 16'hACE1);
    @(negedge clk);
    rst_n = 1'b1;

    tick_once(10'd600, 1'b0);
    chk("idle_tick_state", dut.state_q, ST_IDLE);
    chk("idle_tick_y", bus.offset_y, 620);

    pulse_start();
    chk("start_state", dut.state_q, ST_WAIT_GAP);
    chk("start_gap", dut.gap_q, 30);
    chk("start_count", bus.spawn_count, 0);
    m_count = 0; m_last = 3; prev_x = 440;

    run_gap_and_spawn(30);
    @(negedge clk);
    @(negedge clk);
    chk("enable_holds_no_tick", bus.enable, 1);
    tick_once(10'd599, 1'b0);
    chk("enable_one_tick", bus.enable, 0);
    tick_once(10'd599, 1'b0);
    chk("below_bottom_state", dut.state_q, ST_ACTIVE);
    pulse_start();
    chk("start_ignored_state", dut.state_q, ST_ACTIVE);
    chk("start_ignored_count", bus.spawn_count, 1);
    tick_once(10'd600, 1'b0);
    chk("first_bottom_state", dut.state_q, ST_WAIT_GAP);
    chk("first_bottom_y", bus.offset_y, 620);
    chk("first_bottom_gap", dut.gap_q, 30);

    run_gap_and_spawn(30);
    for (int i = 2; i < 258; i++) begin
      finish_active();
      run_gap_and_spawn(exp_gap(m_count));
    end
    chk("count_saturated", bus.spawn_count, 255);

    // collision wins over a qualifying bottom tick
    tick_once(10'd600, 1'b0);
    chk("pre_col_enable", bus.enable, 0);
    tick_once(10'd600, 1'b1);
    chk("col_state", dut.state_q, ST_FROZEN);
    chk("col_frozen", bus.frozen, 1);
    chk("col_enable", bus.enable, 0);
    chk("col_hold_y", bus.offset_y, 0);
    chk("col_hold_x", bus.offset_x, prev_x);
    chk("col_hold_count", bus.spawn_count, 255);
    tick_once(10'd600, 1'b0);
    chk("frozen_tick_state", dut.state_q, ST_FROZEN);
    chk("frozen_tick_y", bus.offset_y, 0);
    pulse_start();
    chk("restart_state", dut.state_q, ST_WAIT_GAP);
    chk("restart_count", bus.spawn_count, 0);
    chk("restart_y", bus.offset_y, 620);
    chk("restart_frozen", bus.frozen, 0);
    chk("restart_gap", dut.gap_q, 30);
    m_count = 0;

    // collision in WAIT_GAP
    tick_once(10'd0, 1'b1);
    chk("col_wait_state", dut.state_q, ST_FROZEN);
    chk("col_wait_frozen", bus.frozen, 1);
    pulse_start();
    chk("restart2_state", dut.state_q, ST_WAIT_GAP);

    // reset in the middle of an enable window
    run_gap_and_spawn(30);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_enable", bus.enable, 0);
    chk("async_rst_y", bus.offset_y, 620);
    chk("async_rst_state", dut.state_q, ST_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    m_last = 3;

    while (lfsr_cycles < 70000) @(negedge clk);
    chk("lfsr_never_zero", lfsr_zero, 0);
    chk("lfsr_model", dut.lfsr_value, m_lfsr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/enemy_spawner.md
ENEMY_SPAWNER -- requirements
Module: enemy_spawner

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- NUM_LANES, 4: road lanes; power of two.
- LANE_X0, 200: pixel x of lane 0 left edge.
- LANE_W, 80: lane pitch in pixels, equal to car sprite width.
- PARK_Y, 620: off-screen y used while no enemy is live.
- BOTTOM_Y, 600: enemy y meaning "left screen".
- GAP_TICKS, 30: initial inter-spawn gap in ticks.
- GAP_MIN, 8: floor on the gap.
- LFSR_SEED, 16'hACE1: reset value of the LFSR; nonzero.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1: single clock.
- reset, in, 1: asynchronous, active-low reset.
- tick, in, 1: one-cycle game-logic update strobe.
- start, in, 1: one-cycle game start or restart request.
- collision, in, 1: level input from the collision stage.
- enemy_pos_y, in, 10: current y fed back from the downstream enemy stage.
- offset_x, out, 10: spawn x for the enemy stage.
- offset_y, out, 10: spawn y for the enemy stage.
- enable, out, 1: respawn strobe to the enemy stage.
- spawn_count, out, 8: enemies spawned this game, saturating.
- frozen, out, 1: high while in FROZEN.

Function
REQ-003 The block SHALL implement a 16-bit Galois LFSR with mask 16'hB400 that advances every clk cycle and never holds zero.
REQ-004 The FSM SHALL have exactly these states: IDLE, WAIT_GAP, SPAWN, ACTIVE, FROZEN.
REQ-005 IDLE: enable=0 and offset_y=PARK_Y. A start pulse SHALL clear spawn_count, load the gap counter with GAP_TICKS, and move to WAIT_GAP.
REQ-006 WAIT_GAP: the gap counter SHALL decrement only on tick. The cycle on which the counter decrements from 1 to 0 SHALL move to SPAWN on the next clk.
REQ-007 SPAWN lasts exactly one clk. In it, lane = lfsr[1:0]. If lane equals last_lane, lane SHALL be replaced by (last_lane+1) mod NUM_LANES.
REQ-008 In SPAWN, the block SHALL register offset_x = LANE_X0 + lane*LANE_W and offset_y = 0, update last_lane, and increment spawn_count (saturating at 255); then move to ACTIVE.
REQ-009 enable SHALL rise the cycle after SPAWN. It SHALL stay high through and including the next tick cycle, then fall, so the enemy stage samples it exactly once.
REQ-010 ACTIVE: on a tick with enemy_pos_y >= BOTTOM_Y and enable low, the block SHALL set offset_y=PARK_Y, load gap = max(GAP_MIN, GAP_TICKS - spawn_count[7:2]), and move to WAIT_GAP.
REQ-011 collision high in WAIT_GAP, SPAWN or ACTIVE SHALL move to FROZEN on the next clk. collision SHALL take priority over every other transition in the same cycle.
REQ-012 FROZEN: enable=0; offset_x, offset_y and spawn_count hold; frozen=1. start SHALL restart the game exactly as from IDLE (REQ-005), with offset_y=PARK_Y.
REQ-013 start outside IDLE and FROZEN SHALL be ignored. tick while in IDLE or FROZEN SHALL have no effect.
REQ-014 Gap arithmetic SHALL use at least 6 bits with no underflow. The subtraction SHALL be evaluated as signed, or clamped before it, so the result never wraps.
REQ-015 last_lane after reset SHALL be NUM_LANES-1.

Reset
REQ-016 While reset is low, all state SHALL go asynchronously to these values:
- state = IDLE
- lfsr = LFSR_SEED
- offset_x = LANE_X0
- offset_y = PARK_Y
- enable = 0
- spawn_count = 0
- frozen = 0
- gap counter = 0
REQ-017 Reset SHALL be released synchronously by the surrounding design. Reset asserted mid-SPAWN or mid-enable SHALL drop enable in the same cycle.

Structure
REQ-018 The state enum, PARK_Y, BOTTOM_Y and LANE_W SHALL live in the shared game package, because the enemy, collision and VGA stages use them too.
REQ-019 The LFSR SHALL be a separate sub-module named lfsr16 (ports: clk, reset, value[15:0]) so that other stages can reuse it.
REQ-020 All outputs SHALL be registered. No combinational path SHALL run from tick, start, collision or enemy_pos_y to any output.

Verification
REQ-021 Reset, then start, then 30 ticks: SPAWN occurs after the 30th tick; enable is high for exactly one tick window; offset_y=0; offset_x is in {200, 280, 360, 440}; spawn_count=1.
REQ-022 Force enemy_pos_y=600 on a tick in ACTIVE: the next state is WAIT_GAP and offset_y=620. After 30 more ticks a second spawn occurs in a different lane from the first.
REQ-023 Run 100 spawns: no two consecutive lanes are equal; the gap reaches and holds 8 once spawn_count >= 88; spawn_count saturates at 255 when the run is extended past 255 spawns.
REQ-024 Assert collision in the same cycle as a qualifying bottom-of-screen tick: the block enters FROZEN, not WAIT_GAP; outputs hold; frozen=1. A following start gives spawn_count=0, offset_y=620, state WAIT_GAP.
REQ-025 Drive reset low during an enable window: enable=0 and offset_y=620 immediately, before the next clk edge. start pulses in ACTIVE are ignored, and the LFSR is never zero over 70000 cycles.
